ps2_mouse_responder: RTL and testbench
======================================

// Module: ps2_mouse_responder
// PURPOSE
//  Device-side PS/2 mouse protocol engine: answers host commands (FF/F6/EB/F2/F4/F5/F3/E8/FE) with
//  the standard ack/BAT/ID/3-byte movement packets. Sits between a device-side PS/2 byte PHY and a
//  motion source (sim model, USB/serial bridge). Counterpart of the host-side mouse poller.
// PARAMETERS
//  BAT_DELAY      1000      cycles from reset release / FA(of FF) sent to first BAT byte AA
//  STREAM_PERIOD  833333    cycles between stream reports (PS2_MOUSE_STREAM_EN only; 25MHz/30)
// PORTS
//  iClk      in   1  system clock
//  iRst      in   1  asynchronous, active-high reset
//  iRx       in   1  1-cycle strobe: host byte received
//  iRxData   in   8  received host byte, valid with iRx
//  iIdle     in   1  PHY idle, may start a transmit
//  oTx       out  1  1-cycle strobe: send oTxData
//  oTxData   out  8  byte to send, held stable until iTxOk/iTxFail
//  iTxOk     in   1  1-cycle strobe: byte delivered
//  iTxFail   in   1  1-cycle strobe: host inhibited/aborted transfer
//  iDx       in   8  signed X delta, valid with iMoveStb
//  iDy       in   8  signed Y delta (+ = up), valid with iMoveStb
//  iButtons  in   3  {middle,right,left}, level, sampled at packet build
//  iMoveStb  in   1  accumulate iDx/iDy this cycle
//  oStream   out  1  stream reporting enabled
//  oBusy     out  1  response queue non-empty or BAT pending
// BEHAVIOUR
//  Reset values: oTx=0, oTxData=00, oStream=0, oBusy=1 (BAT pending), accumulators 0, queue empty.
//  Accumulators: 10-bit signed X/Y; each iMoveStb adds sign-extended delta, saturating at -256/+255.
//   Overflow flag set when a sum leaves the range, cleared only at packet build.
//  Packet build (1 cycle): b0={Yovf,Xovf,Ysign,Xsign,1'b1,M,R,L}, b1=X[7:0], b2=Y[7:0]; then
//   accumulators/flags cleared; an iMoveStb in the build cycle lands in the cleared accumulator.
//  Response queue: 4 x 8-bit, count 0..4, loaded whole by command decode, drained head-first.
//  FSM:
//   BAT_WAIT: count BAT_DELAY cycles, then queue {AA,00}, -> SEND.
//   IDLE:     on iRx decode -> SEND (or ARG); queue empty, oBusy=0.
//   SEND:     when iIdle: oTx=1 one cycle with head byte, -> WAIT.
//   WAIT:     iTxOk: record byte as last-sent, pop; queue empty -> IDLE (or BAT_WAIT if after FF ack),
//             else -> SEND. iTxFail: keep head, -> SEND (retry, unbounded).
//   ARG:      FA sent for F3/E8; next iRx byte ignored and answered FA -> SEND.
//  Decode: FF -> {FA}, then BAT_WAIT, stream off, accumulators cleared.
//          F6 -> {FA}, stream off, accum cleared. F5 -> {FA}, stream off. F4 -> {FA}, stream on.
//          EB -> {FA,b0,b1,b2}. F2 -> {FA,00}. F3/E8 -> {FA}, -> ARG.
//          FE -> {last-sent byte} (00 if none yet). Any other -> {FE}.
//  iRx in any state except IDLE/ARG: queue flushed, in-flight byte abandoned (await PHY
//   iTxOk/iTxFail ignored), new byte decoded same as IDLE. iRx during BAT_WAIT aborts BAT.
//  iRx and iTxOk same cycle: iRx wins (pop discarded). Latency iRx -> oTx: 2 cycles if iIdle.
//  iRst asserted mid-operation: everything returns to reset values immediately.
// CONFIGURATION
//  PS2_MOUSE_STREAM_EN defined: F4 sets oStream; period counter reloads STREAM_PERIOD; in IDLE with
//   oStream=1, counter 0 and (accum non-zero or buttons changed since last packet) -> build and queue
//   {b0,b1,b2} without FA. Undefined: F4 still acked FA, oStream tied 0, no unsolicited packets,
//   no period counter.
// TESTING
//  1 release iRst, iIdle=1 -> after BAT_DELAY cycles oTxData AA then 00, each with iTxOk; oBusy->0.
//  2 iRx FF -> FA; BAT_DELAY later AA, 00; prior accumulated motion reads 00,00 on next EB.
//  3 dx +5,+3, dy -2, iButtons=001, iRx EB -> FA,29,08,FE; second EB -> FA,09,00,00.
//  4 four iMoveStb dx=+100 then EB -> FA,48,FF,00 (X overflow, clamp 255).
//  5 iTxFail on byte 08 of test 3 -> 08 resent; iRx F5 mid-packet -> queue flushed, only FA sent.
//  6 iRx 12 -> FE; iRx FE -> FE resent; iRx F3 then 64 -> FA, FA; iRx F2 -> FA,00.
//  (STREAM_EN) F4, dx=+1 -> FA, then 08,01,00 within STREAM_PERIOD; no motion -> no packet.

Source files
------------

// File: rtl/ps2_mouse_responder.sv
// Device-side PS/2 mouse engine: decodes host commands, queues ack/BAT/ID/movement replies for the PHY.
// Latency: iRx to oTx is 2 cycles when iIdle; PHY handshake is per byte (iTxOk pops, iTxFail retries).
// Backpressure: bytes wait in SEND until iIdle. Define PS2_MOUSE_STREAM_EN for stream-mode reports.
module ps2_mouse_responder #(
    parameter int BAT_DELAY = 1000
`ifdef PS2_MOUSE_STREAM_EN
    ,
    parameter int STREAM_PERIOD = 833333
`endif
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRx,
    input  logic [7:0] iRxData,
    input  logic       iIdle,
    output logic       oTx,
    output logic [7:0] oTxData,
    input  logic       iTxOk,
    input  logic       iTxFail,
    input  logic [7:0] iDx,
    input  logic [7:0] iDy,
    input  logic [2:0] iButtons,
    input  logic       iMoveStb,
    output logic       oStream,
    output logic       oBusy
);

    localparam logic [2:0] S_BAT  = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_ARG  = 3'd4;

    localparam int BAT_W = (BAT_DELAY > 1) ? $clog2(BAT_DELAY) : 1;
    localparam logic [BAT_W-1:0] BAT_LAST = BAT_W'(BAT_DELAY - 1);

    logic [2:0]       state_q, state_d;
    logic [BAT_W-1:0] bat_cnt_q, bat_cnt_d;
    logic [7:0]       last_q, last_d;
    logic             after_ff_q, after_ff_d;
    logic             to_arg_q, to_arg_d;
    logic             tx_q, tx_d;
    logic [7:0]       txd_q, txd_d;

    logic [7:0]       q_q [4];
    logic [2:0]       cnt_q;
    logic             pop, load;
    logic [31:0]      load_dat;
    logic [2:0]       load_n;

    logic [9:0]       x_q, x_d, y_q, y_d, x_base, y_base, x_sum, y_sum;
    logic             xo_q, xo_d, yo_q, yo_d, xo_base, yo_base, xo_n, yo_n;
    logic             build, clr_cmd, acc_clr;
    logic [7:0]       b0, b1, b2;

`ifdef PS2_MOUSE_STREAM_EN
    localparam int PER_W = $clog2(STREAM_PERIOD + 1);
    localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(STREAM_PERIOD);
    logic             stream_q, stream_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [2:0]       btn_q;
    logic             moved;
    assign moved   = (x_q != '0) || (y_q != '0) || xo_q || yo_q;
    assign oStream = stream_q;
`else
    assign oStream = 1'b0;
`endif

    // Returns {overflow, sum}, clamped to the 9-bit two's complement range -256..+255.
    function automatic logic [10:0] sat_add(input logic [9:0] acc, input logic [7:0] d);
        logic signed [10:0] s;
        s = $signed({acc[9], acc}) + $signed({{3{d[7]}}, d});
        if (s > 11'sd255)       sat_add = {1'b1, 10'h0FF};
        else if (s < -11'sd256) sat_add = {1'b1, 10'h300};
        else                    sat_add = {1'b0, s[9:0]};
    endfunction

    assign b0      = {yo_q, xo_q, y_q[9], x_q[9], 1'b1, iButtons};
    assign b1      = x_q[7:0];
    assign b2      = y_q[7:0];
    assign acc_clr = build | clr_cmd;

    always_comb begin
        x_base  = acc_clr ? '0 : x_q;
        y_base  = acc_clr ? '0 : y_q;
        xo_base = acc_clr ? 1'b0 : xo_q;
        yo_base = acc_clr ? 1'b0 : yo_q;
        {xo_n, x_sum} = sat_add(x_base, iDx);
        {yo_n, y_sum} = sat_add(y_base, iDy);
        x_d  = x_base;
        y_d  = y_base;
        xo_d = xo_base;
        yo_d = yo_base;
        if (iMoveStb) begin
            x_d  = x_sum;
            y_d  = y_sum;
            xo_d = xo_base | xo_n;
            yo_d = yo_base | yo_n;
        end
    end

    always_comb begin
        state_d    = state_q;
        bat_cnt_d  = bat_cnt_q;
        last_d     = last_q;
        after_ff_d = after_ff_q;
        to_arg_d   = to_arg_q;
        tx_d       = 1'b0;
        txd_d      = txd_q;
        pop        = 1'b0;
        load       = 1'b0;
        load_dat   = '0;
        load_n     = '0;
        build      = 1'b0;
        clr_cmd    = 1'b0;
`ifdef PS2_MOUSE_STREAM_EN
        stream_d   = stream_q;
        per_d      = (per_q != '0) ? per_q - 1'b1 : per_q;
`endif
        case (state_q)
            S_BAT: begin
                if (bat_cnt_q == BAT_LAST) begin
                    load     = 1'b1;
                    load_dat = 32'hAA00_0000;
                    load_n   = 3'd2;
                    state_d  = S_SEND;
                end else begin
                    bat_cnt_d = bat_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
`ifdef PS2_MOUSE_STREAM_EN
                if (stream_q && (per_q == '0) && (moved || (iButtons != btn_q))) begin
                    build    = 1'b1;
                    load     = 1'b1;
                    load_dat = {b0, b1, b2, 8'h00};
                    load_n   = 3'd3;
                    per_d    = PER_RELOAD;
                    state_d  = S_SEND;
                end
`endif
            end
            S_SEND: begin
                if (iIdle) begin
                    tx_d    = 1'b1;
                    txd_d   = q_q[0];
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (iTxOk) begin
                    last_d = q_q[0];
                    pop    = 1'b1;
                    if (cnt_q == 3'd1) begin
                        if (after_ff_q) begin
                            state_d    = S_BAT;
                            bat_cnt_d  = '0;
                            after_ff_d = 1'b0;
                        end else if (to_arg_q) begin
                            state_d  = S_ARG;
                            to_arg_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_SEND;
                    end
                end else if (iTxFail) begin
                    state_d = S_SEND;
                end
            end
            S_ARG: ;
            default: state_d = S_IDLE;
        endcase

        // A new host byte pre-empts everything: flush, abandon the in-flight byte, decode afresh.
        if (iRx) begin
            tx_d       = 1'b0;
            txd_d      = txd_q;
            pop        = 1'b0;
            last_d     = last_q;
            build      = 1'b0;
            after_ff_d = 1'b0;
            to_arg_d   = 1'b0;
            load       = 1'b1;
            load_n     = 3'd1;
            load_dat   = 32'hFA00_0000;
            state_d    = S_SEND;
`ifdef PS2_MOUSE_STREAM_EN
            per_d      = (per_q != '0) ? per_q - 1'b1 : per_q;
`endif
            if (state_q != S_ARG) begin
                case (iRxData)
                    8'hFF: begin
                        after_ff_d = 1'b1;
                        clr_cmd    = 1'b1;
`ifdef PS2_MOUSE_STREAM_EN
                        stream_d   = 1'b0;
`endif
                    end
                    8'hF6: begin
                        clr_cmd = 1'b1;
`ifdef PS2_MOUSE_STREAM_EN
                        stream_d = 1'b0;
`endif
                    end
                    8'hF5: begin
`ifdef PS2_MOUSE_STREAM_EN
                        stream_d = 1'b0;
`endif
                    end
                    8'hF4: begin
`ifdef PS2_MOUSE_STREAM_EN
                        stream_d = 1'b1;
                        per_d    = PER_RELOAD;
`endif
                    end
                    8'hEB: begin
                        build    = 1'b1;
                        load_dat = {8'hFA, b0, b1, b2};
                        load_n   = 3'd4;
                    end
                    8'hF2: load_n = 3'd2;
                    8'hF3, 8'hE8: to_arg_d = 1'b1;
                    8'hFE: load_dat = {last_q, 24'h0};
                    default: load_dat = 32'hFE00_0000;
                endcase
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= S_BAT;
            bat_cnt_q  <= '0;
            last_q     <= 8'h00;
            after_ff_q <= 1'b0;
            to_arg_q   <= 1'b0;
            tx_q       <= 1'b0;
            txd_q      <= 8'h00;
            x_q        <= '0;
            y_q        <= '0;
            xo_q       <= 1'b0;
            yo_q       <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < 4; i++) q_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            bat_cnt_q  <= bat_cnt_d;
            last_q     <= last_d;
            after_ff_q <= after_ff_d;
            to_arg_q   <= to_arg_d;
            tx_q       <= tx_d;
            txd_q      <= txd_d;
            x_q        <= x_d;
            y_q        <= y_d;
            xo_q       <= xo_d;
            yo_q       <= yo_d;
            if (load) begin
                q_q[0] <= load_dat[31:24];
                q_q[1] <= load_dat[23:16];
                q_q[2] <= load_dat[15:8];
                q_q[3] <= load_dat[7:0];
                cnt_q  <= load_n;
            end else if (pop) begin
                q_q[0] <= q_q[1];
                q_q[1] <= q_q[2];
                q_q[2] <= q_q[3];
                q_q[3] <= 8'h00;
                cnt_q  <= cnt_q - 3'd1;
            end
        end
    end

`ifdef PS2_MOUSE_STREAM_EN
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stream_q <= 1'b0;
            per_q    <= '0;
            btn_q    <= '0;
        end else begin
            stream_q <= stream_d;
            per_q    <= per_d;
            if (build) btn_q <= iButtons;
        end
    end
`endif

    assign oTx     = tx_q;
    assign oTxData = txd_q;
    assign oBusy   = (cnt_q != 3'd0) || (state_q == S_BAT);

endmodule

// File: tb/tb_ps2_mouse_responder.sv
// Directed bench for ps2_mouse_responder: command table plus hand-written BAT, retry, flush, latency, reset sequences.
module tb_ps2_mouse_responder;
    localparam int BAT = 20;
    localparam int NV  = 16;

    logic       iClk = 1'b0;
    logic       iRst, iRx, iIdle, iTxOk, iTxFail, iMoveStb;
    logic [7:0] iRxData, iDx, iDy;
    logic [2:0] iButtons;
    logic       oTx, oStream, oBusy;
    logic [7:0] oTxData;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [2:0]  nmv;
        logic [31:0] dx;    // move deltas, first move in the top byte
        logic [31:0] dy;
        logic [2:0]  btn;
        logic [2:0]  nexp;
        logic [31:0] exp;   // expected reply bytes, first byte in the top byte
    } vec_t;

    vec_t vecs [NV];

    always #5 iClk = ~iClk;

    ps2_mouse_responder #(.BAT_DELAY(BAT)) dut (
        .iClk(iClk), .iRst(iRst), .iRx(iRx), .iRxData(iRxData), .iIdle(iIdle),
        .oTx(oTx), .oTxData(oTxData), .iTxOk(iTxOk), .iTxFail(iTxFail),
        .iDx(iDx), .iDy(iDy), .iButtons(iButtons), .iMoveStb(iMoveStb),
        .oStream(oStream), .oBusy(oBusy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tx(input string name, input int tmo, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < tmo && !seen; i++) begin
            @(posedge iClk); #1;
            if (oTx) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got no oTx within %0d cycles, expected a byte", name, tmo);
        end
    endtask

    task automatic ack(input bit fail);
        if (fail) iTxFail = 1'b1; else iTxOk = 1'b1;
        @(posedge iClk); #1;
        iTxOk   = 1'b0;
        iTxFail = 1'b0;
    endtask

    task automatic expect_seq(input string name, input int n, input logic [31:0] exp, input int tmo);
        bit seen;
        for (int i = 0; i < n; i++) begin
            wait_tx($sformatf("%s_b%0d", name, i), tmo, seen);
            if (!seen) return;
            chk($sformatf("%s_b%0d", name, i), {24'h0, oTxData}, {24'h0, exp[31-8*i -: 8]});
            ack(1'b0);
        end
    endtask

    task automatic quiet(input string name);
        int n = 0;
        repeat (6) begin
            @(posedge iClk); #1;
            if (oTx) n++;
        end
        chk({name, "_extra_tx"}, n, 0);
        chk({name, "_busy"}, {31'h0, oBusy}, 0);
    endtask

    task automatic send_rx(input logic [7:0] b);
        iRxData = b;
        iRx     = 1'b1;
        @(posedge iClk); #1;
        iRx     = 1'b0;
    endtask

    task automatic move(input logic [7:0] dx, input logic [7:0] dy);
        iDx      = dx;
        iDy      = dy;
        iMoveStb = 1'b1;
        @(posedge iClk); #1;
        iMoveStb = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        int n;

        vecs[0]  = '{8'hEB, 3'd2, 32'h0503_0000, 32'hFE00_0000, 3'b001, 3'd4, 32'hFA29_08FE};
        vecs[1]  = '{8'hEB, 3'd0, 32'h0,         32'h0,         3'b001, 3'd4, 32'hFA09_0000};
        vecs[2]  = '{8'hEB, 3'd4, 32'h6464_6464, 32'h0,         3'b000, 3'd4, 32'hFA48_FF00};
        vecs[3]  = '{8'h12, 3'd0, 32'h0,         32'h0,         3'b000, 3'd1, 32'hFE00_0000};
        vecs[4]  = '{8'hFE, 3'd0, 32'h0,         32'h0,         3'b000, 3'd1, 32'hFE00_0000};
        vecs[5]  = '{8'hF3, 3'd0, 32'h0,         32'h0,         3'b000, 3'd1, 32'hFA00_0000};
        vecs[6]  = '{8'h64, 3'd0, 32'h0,         32'h0,         3'b000, 3'd1, 32'hFA00_0000};
        vecs[7]  = '{8'hF2, 3'd0, 32'h0,         32'h0,         3'b000, 3'd2, 32'hFA00_0000};
        vecs[8]  = '{8'hF6, 3'd1, 32'h0700_0000, 32'h0,         3'b000, 3'd1, 32'hFA00_0000};
        vecs[9]  = '{8'hEB, 3'd0, 32'h0,         32'h0,         3'b000, 3'd4, 32'hFA08_0000};
        vecs[10] = '{8'hEB, 3'd4, 32'h0,         32'h9C9C_9C9C, 3'b000, 3'd4, 32'hFAA8_0000};
        vecs[11] = '{8'hF4, 3'd0, 32'h0,         32'h0,         3'b000, 3'd1, 32'hFA00_0000};
        vecs[12] = '{8'hF5, 3'd0, 32'h0,         32'h0,         3'b000, 3'd1, 32'hFA00_0000};
        vecs[13] = '{8'hE8, 3'd0, 32'h0,         32'h0,         3'b000, 3'd1, 32'hFA00_0000};
        vecs[14] = '{8'h03, 3'd0, 32'h0,         32'h0,         3'b000, 3'd1, 32'hFA00_0000};
        vecs[15] = '{8'hEB, 3'd1, 32'hFD00_0000, 32'h0400_0000, 3'b010, 3'd4, 32'hFA1A_FD04};

        iRst = 1'b1; iRx = 1'b0; iRxData = 8'h00; iIdle = 1'b1; iTxOk = 1'b0; iTxFail = 1'b0;
        iDx = 8'h00; iDy = 8'h00; iButtons = 3'b000; iMoveStb = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        chk("rst_otx",    {31'h0, oTx},     0);
        chk("rst_otxdat", {24'h0, oTxData}, 0);
        chk("rst_stream", {31'h0, oStream}, 0);
        chk("rst_busy",   {31'h0, oBusy},   1);
        iRst = 1'b0;

        // Power-up BAT: AA appears BAT_DELAY cycles after release plus the SEND cycle.
        n = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(posedge iClk); #1;
            n++;
            if (oTx) seen = 1'b1;
        end
        chk("bat_latency", n, BAT + 1);
        chk("bat_aa", {24'h0, oTxData}, 32'hAA);
        if (seen) ack(1'b0);
        expect_seq("bat", 1, 32'h0000_0000, 10);
        quiet("bat");

        for (int k = 0; k < NV; k++) begin
            iButtons = vecs[k].btn;
            for (int m = 0; m < vecs[k].nmv; m++)
                move(vecs[k].dx[31-8*m -: 8], vecs[k].dy[31-8*m -: 8]);
            send_rx(vecs[k].cmd);
            expect_seq($sformatf("vec%0d", k), vecs[k].nexp, vecs[k].exp, 10);
            quiet($sformatf("vec%0d", k));
`ifndef PS2_MOUSE_STREAM_EN
            chk($sformatf("vec%0d_stream", k), {31'h0, oStream}, 0);
`endif
        end

        // FF: ack, fresh BAT, and motion accumulated before the reset is gone.
        iButtons = 3'b000;
        move(8'd9, 8'd0);
        send_rx(8'hFF);
        expect_seq("ff_ack", 1, 32'hFA00_0000, 10);
        chk("ff_busy", {31'h0, oBusy}, 1);
        expect_seq("ff_bat", 2, 32'hAA00_0000, BAT + 10);
        quiet("ff");
        send_rx(8'hEB);
        expect_seq("ff_eb", 4, 32'hFA08_0000, 10);
        quiet("ff_eb");

        // Host inhibits the 08 byte: it must be resent before FE.
        iButtons = 3'b001;
        move(8'h05, 8'hFE);
        move(8'h03, 8'h00);
        send_rx(8'hEB);
        expect_seq("fail_pre", 2, 32'hFA29_0000, 10);
        wait_tx("fail_first", 10, seen);
        if (seen) begin
            chk("fail_first", {24'h0, oTxData}, 32'h08);
            ack(1'b1);
        end
        expect_seq("fail_retry", 2, 32'h08FE_0000, 10);
        quiet("fail");

        // F5 arriving while packet byte 08 is in flight flushes the rest.
        iButtons = 3'b000;
        send_rx(8'hEB);
        expect_seq("flush_pre", 1, 32'hFA00_0000, 10);
        wait_tx("flush_b1", 10, seen);
        if (seen) chk("flush_b1", {24'h0, oTxData}, 32'h08);
        send_rx(8'hF5);
        expect_seq("flush_ack", 1, 32'hFA00_0000, 10);
        quiet("flush");

        // iRx to oTx in exactly two cycles.
        iRxData = 8'h12;
        iRx = 1'b1;
        @(posedge iClk); #1;
        iRx = 1'b0;
        chk("lat_1cyc", {31'h0, oTx}, 0);
        @(posedge iClk); #1;
        chk("lat_2cyc", {31'h0, oTx}, 1);
        chk("lat_data", {24'h0, oTxData}, 32'hFE);
        if (oTx) ack(1'b0);
        quiet("lat");

        // Asynchronous reset while a byte is on oTx.
        send_rx(8'hEB);
        wait_tx("rst_pre", 10, seen);
        iRst = 1'b1;
        #1;
        chk("rstmid_otx",    {31'h0, oTx},     0);
        chk("rstmid_otxdat", {24'h0, oTxData}, 0);
        chk("rstmid_busy",   {31'h0, oBusy},   1);
        @(posedge iClk); #1;
        iRst = 1'b0;
        expect_seq("rstmid_bat", 2, 32'hAA00_0000, BAT + 10);
        quiet("rstmid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
